// File: rtl/onchip_ram_writer_pkg.sv
// Shared types and helpers for the on-chip RAM sample writer.
// Holds the control FSM state encoding, the lane counter type, the RAM size
// and the lane-enable helper used for both full and partial word writes.
package onchip_ram_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } writer_state_t;

   typedef logic [1:0] lane_cnt_t;

   localparam int RAM_WORDS = 14120;

   // A count of 0 means all four lanes are filled; 1..3 give the low lanes only.
   function automatic logic [3:0] be_from_count(input lane_cnt_t count);
      logic [3:0] be;
      case (count)
         2'd1:    be = 4'h1;
         2'd2:    be = 4'h3;
         2'd3:    be = 4'h7;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sample_byte_packer.sv
// Gathers accepted sample bytes into little-endian 32-bit words.
// The three low lanes are held in a register; the fourth byte is combined
// directly into full_word so a word can leave on the same cycle it completes.
// Lanes not yet filled always read as zero, so partial_word is flush-ready.
module sample_byte_packer
   import onchip_ram_writer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        accept,
   input  logic        clear,
   input  logic [7:0]  data,
   output lane_cnt_t   lane_cnt,
   output logic        word_ready,
   output logic [31:0] full_word,
   output logic [31:0] partial_word
);

   logic [23:0] lane_reg;

   // Fill the next lane on each accepted byte; empty the word once it completes or is flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_cnt <= '0;
         lane_reg <= '0;
      end else if (clear || (accept && lane_cnt == 2'd3)) begin
         lane_cnt <= '0;
         lane_reg <= '0;
      end else if (accept) begin
         case (lane_cnt)
            2'd0:    lane_reg[7:0]   <= data;
            2'd1:    lane_reg[15:8]  <= data;
            default: lane_reg[23:16] <= data;
         endcase
         lane_cnt <= lane_cnt + 2'd1;
      end
   end

   assign word_ready   = accept && (lane_cnt == 2'd3);
   assign full_word    = {data, lane_reg};
   assign partial_word = {8'h00, lane_reg};

endmodule

// File: rtl/onchip_ram_sample_writer.sv
// Streams 8-bit sensor samples into a ping-pong ring in on-chip RAM through
// a zero-wait-state Avalon-MM write port. Words are packed four samples at a
// time; each half of the ring raises a sticky done flag for firmware, and
// capture stalls (dropping and counting samples) while the half it would
// write into has not yet been acknowledged.
module onchip_ram_sample_writer
   import onchip_ram_writer_pkg::*;
#(
   parameter int BASE_WORD   = 0,
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_W      = 14
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              flush,
   input  logic              sample_valid,
   input  logic [7:0]        sample_data,
   output logic              sample_ready,
   input  logic [1:0]        ack_half,
   output logic [1:0]        half_done,
   output logic [15:0]       overrun_cnt,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   output logic              ram_clken
);

   localparam logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_WORD);
   localparam logic [ADDR_W-1:0] LAST_OFFSET = ADDR_W'(DEPTH_WORDS - 1);
   localparam logic [ADDR_W-1:0] HALF_OFFSET = ADDR_W'(DEPTH_WORDS / 2);
   localparam logic [ADDR_W-1:0] HALF_A_LAST = ADDR_W'(DEPTH_WORDS / 2 - 1);

   writer_state_t     state;
   writer_state_t     state_next;
   lane_cnt_t         lane_cnt;
   logic              word_ready;
   logic [31:0]       full_word;
   logic [31:0]       partial_word;
   logic              accept;
   logic              cur_half;
   logic              blocked;
   logic              pack_accept;
   logic              drop;
   logic              flush_write;
   logic              pack_clear;
   logic              do_write;
   logic [3:0]        write_be;
   logic [31:0]       write_data;
   logic [ADDR_W-1:0] written_ptr;
   logic [1:0]        half_set;

   sample_byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .accept       (pack_accept),
      .clear        (pack_clear),
      .data         (sample_data),
      .lane_cnt     (lane_cnt),
      .word_ready   (word_ready),
      .full_word    (full_word),
      .partial_word (partial_word)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture runs while enabled; any stop request passes through a single FLUSH cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (flush || !enable) state_next = FLUSH;
         FLUSH:   state_next = enable ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-cycle decisions: accept or drop the sample, and what (if anything) to write.
   always_comb begin
      accept      = (state == RUN) && sample_valid;
      cur_half    = (wr_ptr >= HALF_OFFSET);
      blocked     = (lane_cnt == 2'd0) && half_done[cur_half];
      pack_accept = accept && !blocked;
      drop        = accept && blocked;
      flush_write = (state == FLUSH) && (lane_cnt != 2'd0);
      pack_clear  = (state == FLUSH);
      do_write    = word_ready || flush_write;
      write_be    = be_from_count(flush_write ? lane_cnt : 2'd0);
      write_data  = flush_write ? partial_word : full_word;
   end

   // Ready is registered from the next state so it is high exactly while in RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_ready <= 1'b0;
      end else begin
         sample_ready <= (state_next == RUN);
      end
   end

   // Avalon write strobe, word payload and ring pointer advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_write      <= 1'b0;
         ram_byteenable <= '0;
         ram_writedata  <= '0;
         ram_address    <= '0;
         written_ptr    <= '0;
         wr_ptr         <= '0;
      end else begin
         ram_write <= do_write;
         if (do_write) begin
            ram_byteenable <= write_be;
            ram_writedata  <= write_data;
            ram_address    <= BASE_ADDR + wr_ptr;
            written_ptr    <= wr_ptr;
            wr_ptr         <= (wr_ptr == LAST_OFFSET) ? '0 : wr_ptr + 1'b1;
         end
      end
   end

   assign half_set[0] = ram_write && (written_ptr == HALF_A_LAST);
   assign half_set[1] = ram_write && (written_ptr == LAST_OFFSET);

   // Sticky half flags; a completing write beats a same-cycle acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         half_done <= '0;
      end else begin
         half_done <= (half_done & ~ack_half) | half_set;
      end
   end

   // Saturating count of samples dropped while the target half is still unacknowledged.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_cnt <= '0;
      end else if (drop && (overrun_cnt != 16'hFFFF)) begin
         overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

   assign ram_chipselect = ram_write;
   assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_ram_sample_writer.sv
// Self-checking bench for onchip_ram_sample_writer on a small 4-word ring at
// base word 100. Every expected RAM write is queued before its bytes are sent;
// a monitor pops and compares on each ram_write strobe. Flags, counters and
// pointers are compared directly at fixed points in the stimulus.
module tb_onchip_ram_sample_writer;

   localparam int BASE_WORD   = 100;
   localparam int DEPTH_WORDS = 4;
   localparam int ADDR_W      = 14;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              flush = 1'b0;
   logic              sample_valid = 1'b0;
   logic [7:0]        sample_data = 8'h00;
   logic              sample_ready;
   logic [1:0]        ack_half = 2'b00;
   logic [1:0]        half_done;
   logic [15:0]       overrun_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect;
   logic              ram_write;
   logic [31:0]       ram_writedata;
   logic              ram_clken;

   wr_t exp_q[$];
   wr_t exp_item;
   int  n_compared   = 0;
   int  n_mismatched = 0;

   onchip_ram_sample_writer #(
      .BASE_WORD   (BASE_WORD),
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .flush          (flush),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .sample_ready   (sample_ready),
      .ack_half       (ack_half),
      .half_done      (half_done),
      .overrun_cnt    (overrun_cnt),
      .wr_ptr         (wr_ptr),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one byte for exactly one cycle, from one falling edge to the next.
   task automatic applyStimulus(input logic [7:0] b);
      sample_valid = 1'b1;
      sample_data  = b;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic expectWrite(input int offset, input logic [3:0] be, input logic [31:0] data);
      wr_t item;
      item.addr = ADDR_W'(BASE_WORD + offset);
      item.be   = be;
      item.data = data;
      exp_q.push_back(item);
   endtask

   task automatic applyReset();
      reset        = 1'b1;
      sample_valid = 1'b0;
      flush        = 1'b0;
      ack_half     = 2'b00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitReady();
      int n = 0;
      while (!sample_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sample_ready_rise", {31'd0, sample_ready}, 32'd1);
   endtask

   task automatic drainQueue(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, exp_q.size(), 32'd0);
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   always @(posedge clk) begin
      #1;
      if (ram_write) begin
         checkOutput("chipselect", {31'd0, ram_chipselect}, 32'd1);
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_write: actual addr=%0d be=%h data=%h required none", ram_address, ram_byteenable, ram_writedata);
         end else begin
            exp_item = exp_q.pop_front();
            checkOutput("wr_addr", {18'd0, ram_address}, {18'd0, exp_item.addr});
            checkOutput("wr_be",   {28'd0, ram_byteenable}, {28'd0, exp_item.be});
            checkOutput("wr_data", ram_writedata, exp_item.data);
         end
      end
   end

   initial begin
      // Reset state.
      applyReset();
      checkOutput("rst_ram_write",   {31'd0, ram_write}, 32'd0);
      checkOutput("rst_ram_clken",   {31'd0, ram_clken}, 32'd1);
      checkOutput("rst_ready",       {31'd0, sample_ready}, 32'd0);
      checkOutput("rst_half_done",   {30'd0, half_done}, 32'd0);
      checkOutput("rst_overrun",     {16'd0, overrun_cnt}, 32'd0);
      checkOutput("rst_wr_ptr",      {18'd0, wr_ptr}, 32'd0);
      checkOutput("rst_address",     {18'd0, ram_address}, 32'd0);
      checkOutput("rst_be",          {28'd0, ram_byteenable}, 32'd0);

      // One full word of four consecutive bytes.
      $display("[TB] full word");
      enable = 1'b1;
      @(negedge clk);
      waitReady();
      expectWrite(0, 4'hF, 32'h04030201);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      applyStimulus(8'h04);
      drainQueue("t1_drain");
      checkOutput("t1_wr_ptr", {18'd0, wr_ptr}, 32'd1);

      // Partial word flushed while disabling; bytes during FLUSH/IDLE ignored.
      $display("[TB] partial flush");
      applyReset();
      waitReady();
      expectWrite(0, 4'h7, 32'h00CCBBAA);
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      applyStimulus(8'hCC);
      flush  = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      applyStimulus(8'h77);
      repeat (3) applyStimulus(8'h55);
      drainQueue("t2_drain");
      checkOutput("t2_wr_ptr", {18'd0, wr_ptr}, 32'd1);
      checkOutput("t2_idle_ready", {31'd0, sample_ready}, 32'd0);
      enable = 1'b1;
      @(negedge clk);
      waitReady();
      expectWrite(1, 4'hF, 32'h44332211);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (3) @(negedge clk);
      drainQueue("t2_empty_flush_drain");
      checkOutput("t2_empty_flush_wr_ptr", {18'd0, wr_ptr}, 32'd2);
      checkOutput("t2_back_to_run", {31'd0, sample_ready}, 32'd1);

      // Fill the whole ring: half flags and pointer wrap.
      $display("[TB] ring fill");
      applyReset();
      waitReady();
      expectWrite(0, 4'hF, 32'h13121110);
      expectWrite(1, 4'hF, 32'h17161514);
      expectWrite(2, 4'hF, 32'h1B1A1918);
      expectWrite(3, 4'hF, 32'h1F1E1D1C);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(8'h10 + i));
         if (i == 8) checkOutput("t3_half_a_done", {30'd0, half_done}, 32'd1);
      end

      // Keep streaming without acknowledge: samples are dropped and counted.
      $display("[TB] overrun");
      applyStimulus(8'hE0);
      checkOutput("t3_both_done", {30'd0, half_done}, 32'd3);
      checkOutput("t3_wrap", {18'd0, wr_ptr}, 32'd0);
      for (int i = 1; i < 5; i++) applyStimulus(8'(8'hE0 + i));
      checkOutput("t4_overrun", {16'd0, overrun_cnt}, 32'd5);
      checkOutput("t4_wr_ptr_held", {18'd0, wr_ptr}, 32'd0);
      drainQueue("t3_drain");
      ack_half = 2'b01;
      @(negedge clk);
      ack_half = 2'b00;
      checkOutput("t4_after_ack", {30'd0, half_done}, 32'd2);
      expectWrite(0, 4'hF, 32'hA4A3A2A1);
      applyStimulus(8'hA1);
      applyStimulus(8'hA2);
      applyStimulus(8'hA3);
      applyStimulus(8'hA4);

      // Acknowledge in the same cycle the half flag is being set: set wins.
      $display("[TB] ack vs set");
      expectWrite(1, 4'hF, 32'hB4B3B2B1);
      applyStimulus(8'hB1);
      applyStimulus(8'hB2);
      applyStimulus(8'hB3);
      applyStimulus(8'hB4);
      ack_half = 2'b01;
      @(negedge clk);
      ack_half = 2'b00;
      checkOutput("t5_set_wins", {30'd0, half_done}, 32'd3);
      checkOutput("t5_overrun_kept", {16'd0, overrun_cnt}, 32'd5);
      checkOutput("t5_wr_ptr", {18'd0, wr_ptr}, 32'd2);
      drainQueue("t5_drain");

      // Reset in the middle of a word, and in the cycle a word completes.
      $display("[TB] reset mid-word");
      ack_half = 2'b11;
      @(negedge clk);
      ack_half = 2'b00;
      applyStimulus(8'hC1);
      applyStimulus(8'hC2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("t6_ram_write", {31'd0, ram_write}, 32'd0);
      checkOutput("t6_wr_ptr", {18'd0, wr_ptr}, 32'd0);
      checkOutput("t6_half_done", {30'd0, half_done}, 32'd0);
      checkOutput("t6_overrun", {16'd0, overrun_cnt}, 32'd0);
      waitReady();
      applyStimulus(8'hE1);
      applyStimulus(8'hE2);
      applyStimulus(8'hE3);
      reset        = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 8'hE4;
      @(negedge clk);
      reset        = 1'b0;
      sample_valid = 1'b0;
      checkOutput("t6_cancelled_write", {31'd0, ram_write}, 32'd0);
      waitReady();
      expectWrite(0, 4'hF, 32'hD4D3D2D1);
      applyStimulus(8'hD1);
      applyStimulus(8'hD2);
      applyStimulus(8'hD3);
      applyStimulus(8'hD4);
      drainQueue("t6_drain");
      checkOutput("t6_wr_ptr_after", {18'd0, wr_ptr}, 32'd1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
